// File: rtl/lcd_hd44780_ctrl_if.sv
// rtl/lcd_hd44780_ctrl_if.sv - io_lcd request side and HD44780 pin side of the LCD controller
interface lcd_hd44780_ctrl_if;
  logic [31:0] lcd_word;
  logic        ovf_clr;
  logic        lcd_on;
  logic        lcd_rs;
  logic        lcd_rw;
  logic        lcd_en;
  logic [7:0]  lcd_data;
  logic        busy;
  logic        pend;
  logic        ovf;

  modport master (
    output lcd_word, ovf_clr,
    input  lcd_on, lcd_rs, lcd_rw, lcd_en, lcd_data, busy, pend, ovf
  );

  modport slave (
    input  lcd_word, ovf_clr,
    output lcd_on, lcd_rs, lcd_rw, lcd_en, lcd_data, busy, pend, ovf
  );
endinterface

// File: rtl/lcd_hd44780_ctrl.sv
// rtl/lcd_hd44780_ctrl.sv - HD44780 write-cycle timing controller driven by the io_lcd register
// Optional power-up init sequence (PWR_WAIT + 4-command ROM) enabled by defining LCD_AUTO_INIT_EN.
module lcd_hd44780_ctrl #(
  parameter int T_SETUP     = 2,
  parameter int T_PULSE     = 12,
  parameter int T_HOLD      = 2,
  parameter int T_EXEC      = 2000,
  parameter int T_EXEC_LONG = 82000,
`ifdef LCD_AUTO_INIT_EN
  parameter int T_PWRUP     = 750000,
`endif
  parameter int CNT_WIDTH   = 20
) (
  input  logic              clk_i,
  input  logic              rst_i,
  lcd_hd44780_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_PULSE,
    S_HOLD,
    S_EXEC
`ifdef LCD_AUTO_INIT_EN
    , S_PWR_WAIT
`endif
  } state_t;

  state_t               state_q, state_n;
  logic [CNT_WIDTH-1:0] timer_q, timer_load, timer_rst;
  logic                 prev_en_q, on_q, rs_q, ovf_q;
  logic [7:0]           data_q;
  logic                 pend_full_q, pend_rs_q;
  logic [7:0]           pend_data_q;

  logic req, timer_zero, busy_state, exec_done, init_more, long_cmd;
  logic start_new, take_pend, store_pend, drop_req;
  logic unused_word_bits;

  assign unused_word_bits = ^bus.lcd_word[30:11];

  // Only a rising EN edge with RW=0 counts; reads are silently ignored.
  assign req        = bus.lcd_word[8] & ~prev_en_q & ~bus.lcd_word[9];
  assign timer_zero = (timer_q == '0);
  assign busy_state = (state_q != S_IDLE);
  assign exec_done  = (state_q == S_EXEC) && timer_zero;
  assign long_cmd   = ~rs_q && ((data_q == 8'h01) || (data_q == 8'h02) || (data_q == 8'h03));

`ifdef LCD_AUTO_INIT_EN
  logic       init_active_q;
  logic [1:0] init_idx_q;
  logic       pwr_done;

  function automatic logic [7:0] init_rom(input logic [1:0] idx);
    case (idx)
      2'd0:    init_rom = 8'h38;
      2'd1:    init_rom = 8'h0C;
      2'd2:    init_rom = 8'h01;
      default: init_rom = 8'h06;
    endcase
  endfunction

  assign init_more = init_active_q && (init_idx_q != 2'd3);
  assign pwr_done  = (state_q == S_PWR_WAIT) && timer_zero;
  assign timer_rst = CNT_WIDTH'(T_PWRUP - 1);
`else
  assign init_more = 1'b0;
  assign timer_rst = '0;
`endif

  // A request landing on the final EXEC cycle with nothing queued starts directly,
  // so the controller never parks in IDLE with a full buffer.
  assign start_new  = req && ((state_q == S_IDLE) || (exec_done && !pend_full_q && !init_more));
  assign take_pend  = exec_done && pend_full_q && !init_more;
  assign store_pend = req && !start_new && (!pend_full_q || take_pend);
  assign drop_req   = req && !start_new && pend_full_q && !take_pend;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
`ifdef LCD_AUTO_INIT_EN
      state_q <= S_PWR_WAIT;
`else
      state_q <= S_IDLE;
`endif
      timer_q <= timer_rst;
    end else begin
      state_q <= state_n;
      if (state_n != state_q)
        timer_q <= timer_load;
      else if (!timer_zero)
        timer_q <= timer_q - CNT_WIDTH'(1);
    end
  end

  always_comb begin
    state_n = state_q;
    case (state_q)
      S_IDLE:  if (start_new)  state_n = S_SETUP;
      S_SETUP: if (timer_zero) state_n = S_PULSE;
      S_PULSE: if (timer_zero) state_n = S_HOLD;
      S_HOLD:  if (timer_zero) state_n = S_EXEC;
      S_EXEC:  if (timer_zero)
                 state_n = (init_more || pend_full_q || start_new) ? S_SETUP : S_IDLE;
`ifdef LCD_AUTO_INIT_EN
      S_PWR_WAIT: if (timer_zero) state_n = S_SETUP;
`endif
      default: state_n = S_IDLE;
    endcase
  end

  // Load N-1 on entry so each state lasts exactly N cycles.
  always_comb begin
    timer_load = '0;
    case (state_n)
      S_SETUP: timer_load = CNT_WIDTH'(T_SETUP - 1);
      S_PULSE: timer_load = CNT_WIDTH'(T_PULSE - 1);
      S_HOLD:  timer_load = CNT_WIDTH'(T_HOLD - 1);
      S_EXEC:  timer_load = long_cmd ? CNT_WIDTH'(T_EXEC_LONG - 1) : CNT_WIDTH'(T_EXEC - 1);
      default: timer_load = '0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      prev_en_q   <= 1'b0;
      on_q        <= 1'b0;
      rs_q        <= 1'b0;
      data_q      <= 8'h00;
      pend_full_q <= 1'b0;
      pend_rs_q   <= 1'b0;
      pend_data_q <= 8'h00;
      ovf_q       <= 1'b0;
    end else begin
      prev_en_q <= bus.lcd_word[8];
      on_q      <= bus.lcd_word[31];

      if (start_new) begin
        rs_q   <= bus.lcd_word[10];
        data_q <= bus.lcd_word[7:0];
      end else if (take_pend) begin
        rs_q   <= pend_rs_q;
        data_q <= pend_data_q;
      end
`ifdef LCD_AUTO_INIT_EN
      else if (pwr_done) begin
        rs_q   <= 1'b0;
        data_q <= init_rom(2'd0);
      end else if (exec_done && init_more) begin
        rs_q   <= 1'b0;
        data_q <= init_rom(init_idx_q + 2'd1);
      end
`endif

      if (store_pend) begin
        pend_full_q <= 1'b1;
        pend_rs_q   <= bus.lcd_word[10];
        pend_data_q <= bus.lcd_word[7:0];
      end else if (take_pend) begin
        pend_full_q <= 1'b0;
      end

      if (drop_req)
        ovf_q <= 1'b1;
      else if (bus.ovf_clr)
        ovf_q <= 1'b0;
    end
  end

`ifdef LCD_AUTO_INIT_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      init_active_q <= 1'b0;
      init_idx_q    <= 2'd0;
    end else if (pwr_done) begin
      init_active_q <= 1'b1;
      init_idx_q    <= 2'd0;
    end else if (exec_done && init_active_q) begin
      if (init_idx_q == 2'd3)
        init_active_q <= 1'b0;
      else
        init_idx_q <= init_idx_q + 2'd1;
    end
  end
`endif

  always_comb begin
    bus.lcd_en   = (state_q == S_PULSE);
    bus.busy     = busy_state | pend_full_q;
    bus.pend     = pend_full_q;
    bus.ovf      = ovf_q;
    bus.lcd_on   = on_q;
    bus.lcd_rs   = rs_q;
    bus.lcd_rw   = 1'b0;
    bus.lcd_data = data_q;
  end

endmodule

// File: tb/tb_lcd_hd44780_ctrl.sv
// tb/tb_lcd_hd44780_ctrl.sv - self-checking bench for lcd_hd44780_ctrl against a transfer-age model
module tb_lcd_hd44780_ctrl;
  localparam int TS = 2;
  localparam int TP = 4;
  localparam int TH = 2;
  localparam int TE = 10;
  localparam int TL = 30;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  lcd_hd44780_ctrl_if bus();

  lcd_hd44780_ctrl #(
    .T_SETUP(TS), .T_PULSE(TP), .T_HOLD(TH), .T_EXEC(TE), .T_EXEC_LONG(TL), .CNT_WIDTH(20)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus(bus)
  );

  int total = 0;
  int bad   = 0;
  bit chk_on = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Model: a transfer is "age" cycles old; its outputs follow from age alone.
  typedef struct {
    bit       active;
    int       age;
    int       len;
    bit       rs;
    bit [7:0] data;
    bit       pf;
    bit       prs;
    bit [7:0] pdata;
    bit       ovf;
    bit       on;
    bit       prev;
  } model_t;

  model_t m;

  function automatic model_t start(model_t s, bit rs, bit [7:0] d);
    model_t n = s;
    n.active = 1'b1;
    n.age    = 0;
    n.rs     = rs;
    n.data   = d;
    n.len    = TS + TP + TH + ((!rs && d >= 8'h01 && d <= 8'h03) ? TL : TE);
    return n;
  endfunction

  function automatic model_t step(model_t s, bit r, bit [31:0] w, bit clr);
    model_t n = s;
    bit req, fin, drop;
    if (r) begin
      n = '{default: 0};
      return n;
    end
    n.on   = w[31];
    n.prev = w[8];
    req    = w[8] && !s.prev && !w[9];
    fin    = s.active && (s.age == s.len - 1);
    drop   = 1'b0;
    if (s.active) begin
      if (fin) begin
        if (s.pf) begin
          n = start(n, s.prs, s.pdata);
          n.pf = 1'b0;
        end else begin
          n.active = 1'b0;
        end
      end else begin
        n.age = s.age + 1;
      end
    end
    if (req) begin
      if (!s.active || (fin && !s.pf)) n = start(n, w[10], w[7:0]);
      else if (!s.pf || fin) begin
        n.pf    = 1'b1;
        n.prs   = w[10];
        n.pdata = w[7:0];
      end else drop = 1'b1;
    end
    n.ovf = drop ? 1'b1 : (clr ? 1'b0 : s.ovf);
    return n;
  endfunction

  always @(posedge clk) m <= step(m, rst, bus.lcd_word, bus.ovf_clr);

  always @(negedge clk) begin
    if (chk_on) begin
      chk("m_en",   bus.lcd_en, (m.active && m.age >= TS && m.age < TS + TP));
      chk("m_busy", bus.busy, (m.active || m.pf));
      chk("m_pend", bus.pend, m.pf);
      chk("m_ovf",  bus.ovf, m.ovf);
      chk("m_on",   bus.lcd_on, m.on);
      chk("m_rs",   bus.lcd_rs, m.rs);
      chk("m_data", bus.lcd_data, m.data);
      chk("m_rw",   bus.lcd_rw, 0);
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  // Counts busy cycles from the current one, en cycles and offset of the first en cycle.
  task automatic measure(output int nb, output int ne, output int fe);
    nb = 0; ne = 0; fe = -1;
    for (int i = 0; i < 200; i++) begin
      if (!bus.busy) break;
      if (bus.lcd_en) begin
        if (fe < 0) fe = i;
        ne++;
      end
      nb++;
      @(negedge clk);
    end
  endtask

  int nb, ne, fe;

  initial begin
    bus.lcd_word = 32'h0;
    bus.ovf_clr  = 1'b0;
    rst = 1'b1;
    repeat (3) tick();
    chk("rst_en", bus.lcd_en, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_data", bus.lcd_data, 0);
    chk("rst_ovf", bus.ovf, 0);
    chk("rst_pend", bus.pend, 0);
    chk("rst_on", bus.lcd_on, 0);
    rst = 1'b0;
    chk_on = 1'b1;
    tick();

    // Normal data write
    bus.lcd_word = 32'h0000_0541;
    tick();
    chk("w1_rs", bus.lcd_rs, 1);
    chk("w1_data", bus.lcd_data, 8'h41);
    chk("w1_busy", bus.busy, 1);
    chk("w1_en", bus.lcd_en, 0);
    measure(nb, ne, fe);
    chk("w1_busy_len", nb, 18);
    chk("w1_en_len", ne, 4);
    chk("w1_en_first", fe, 2);
    tick();
    chk("w1_level_no_req", bus.busy, 0);
    bus.lcd_word = 32'h0;
    tick();

    // Clear display uses the long execution wait
    bus.lcd_word = 32'h0000_0101;
    tick();
    chk("clr_data", bus.lcd_data, 8'h01);
    chk("clr_rs", bus.lcd_rs, 0);
    measure(nb, ne, fe);
    chk("clr_busy_len", nb, 38);
    chk("clr_en_len", ne, 4);
    bus.lcd_word = 32'h0;
    tick();

    // Pending and overflow during EXEC
    bus.lcd_word = 32'h0000_0541;
    tick();
    repeat (8) tick();
    bus.lcd_word = 32'h0;
    tick();
    bus.lcd_word = 32'h0000_0542;
    tick();
    chk("q_pend", bus.pend, 1);
    bus.lcd_word = 32'h0;
    tick();
    bus.lcd_word = 32'h0000_0543;
    tick();
    chk("q_ovf", bus.ovf, 1);
    chk("q_pend_kept", bus.pend, 1);
    bus.lcd_word = 32'h0;
    repeat (5) tick();
    chk("q_last_exec_data", bus.lcd_data, 8'h41);
    tick();
    chk("q_next_data", bus.lcd_data, 8'h42);
    chk("q_next_pend", bus.pend, 0);
    bus.ovf_clr = 1'b1;
    tick();
    bus.ovf_clr = 1'b0;
    chk("q_ovf_clr", bus.ovf, 0);
    measure(nb, ne, fe);
    chk("q_rest_len", nb, 17);

    // Request on the EXEC exit cycle with the buffer full
    bus.lcd_word = 32'h0000_0541;
    tick();
    bus.lcd_word = 32'h0;
    tick();
    bus.lcd_word = 32'h0000_0542;
    tick();
    bus.lcd_word = 32'h0;
    repeat (15) tick();
    bus.lcd_word = 32'h0000_0543;
    tick();
    chk("x_data", bus.lcd_data, 8'h42);
    chk("x_pend", bus.pend, 1);
    chk("x_ovf", bus.ovf, 0);
    bus.lcd_word = 32'h0;
    measure(nb, ne, fe);
    chk("x_busy_len", nb, 36);

    // Read request is ignored; ON bit is a registered copy
    bus.lcd_word = 32'h0000_0300;
    tick();
    chk("rd_busy", bus.busy, 0);
    chk("rd_ovf", bus.ovf, 0);
    chk("rd_pend", bus.pend, 0);
    bus.lcd_word = 32'h8000_0000;
    tick();
    chk("on_set", bus.lcd_on, 1);

    // Reset mid-pulse with a pending entry
    bus.lcd_word = 32'h0000_0541;
    tick();
    bus.lcd_word = 32'h0;
    tick();
    bus.lcd_word = 32'h0000_0542;
    tick();
    chk("r_en_before", bus.lcd_en, 1);
    chk("r_pend_before", bus.pend, 1);
    rst = 1'b1;
    bus.lcd_word = 32'h0;
    tick();
    chk("r_en", bus.lcd_en, 0);
    chk("r_pend", bus.pend, 0);
    chk("r_busy", bus.busy, 0);
    chk("r_data", bus.lcd_data, 0);
    rst = 1'b0;
    repeat (3) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

endmodule
